uart_bus_arbiter: RTL and testbench
===================================

Name: uart_bus_arbiter

Overview:
- Shares the single 32-bit register port of the UART controller between NUM_REQ requesters, for example the CPU core and a boot/debug loader.
- Arbitrates round-robin and serialises one transaction at a time.
- Converts each level-held request into the exactly-one-cycle wren/rden pulse the UART controller needs. This prevents a double RX-FIFO pop.
- Returns the read data or a write completion as a one-cycle ack to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BASE_ADDR, 32'h10010000, UART window; bits [31:16] are compared.
- TIMEOUT_CYC, 16, read-response timeout in cycles; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  per-requester request, held high until ack
- req_we_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  32*NUM_REQ  flattened addresses; requester i occupies [32i+31:32i]
- req_wdata_i  in  32*NUM_REQ  flattened write data
- ack_o  out  NUM_REQ  one-hot, one-cycle completion
- rdata_o  out  32  read data, valid with ack_o
- err_o  out  1  completion error flag, valid with ack_o
- m_addr_o  out  32  to UART controller address
- m_wren_o  out  1  write pulse
- m_rden_o  out  1  read pulse
- m_wdata_o  out  32  write data
- m_rdata_i  in  32  UART controller read data
- m_valid_i  in  1  UART controller read-valid

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0, and the timeout counter is cleared.
- Reset may assert mid-transaction: the transaction is abandoned, no ack is issued, and the requester must re-request.
- States: IDLE, WAIT_RD, ACK.
- IDLE:
  - If any req_i bit is high, pick a winner by round-robin starting at the pointer.
  - Latch its index, we, addr and wdata; m_addr_o and m_wdata_o hold the latched values until the next grant.
  - Advance the pointer to winner+1, wrapping modulo NUM_REQ.
- IDLE, winner is a write: assert m_wren_o for one cycle and go to ACK.
- IDLE, winner is a read inside the UART window (addr[31:16]==BASE_ADDR[31:16] and addr[5:2]==0): assert m_rden_o for one cycle and go to WAIT_RD.
- IDLE, winner is any other read (unmapped, or no responder): issue no pulse, set rdata=0 and err=1, go to ACK.
- WAIT_RD: on m_valid_i, capture m_rdata_i, set err=0, go to ACK.
- ACK: drive ack_o[winner]=1 for one cycle together with rdata_o/err_o, then return to IDLE.
- rdata_o and err_o hold their values until the next ack.
- Latency, with the request seen in cycle 0:
  - Write: m_wren_o is high in cycle 1 and ack_o in cycle 2.
  - Read: m_rden_o is high in cycle 1, m_valid_i arrives in cycle 2, and ack_o plus rdata_o appear in cycle 3.
- A requester must drop req_i in the cycle after its ack. A req_i still high in that cycle is a new transaction.
- Changes to req_i, addr or wdata during a transaction are ignored, because the fields are latched.
- Throughput: at most one transaction per 3 cycles for writes and 4 cycles for reads.
- Simultaneous requests: exactly one grant; the others wait.
- Starvation-free: a held request is served within NUM_REQ grants.
- m_wren_o and m_rden_o are never both high, and neither is high for two consecutive cycles.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined: WAIT_RD counts cycles. If m_valid_i is still absent after TIMEOUT_CYC cycles, go to ACK with rdata=0 and err=1.
- When undefined: WAIT_RD waits indefinitely, and err_o is set only by the unmapped-read path.

Decomposition:
- Package uart_arb_pkg holds:
  - state encodings (IDLE=0, WAIT_RD=1, ACK=2);
  - the register offset constants RBR=0x0, THR=0x4;
  - BASE_ADDR_DEFAULT.
- Sub-module rr_arbiter: req vector plus pointer in, one-hot grant and encoded index out; pure combinational. Pointer storage stays in the parent.

Test Plan:
- Write: req0 write addr 0x10010004 wdata 0x41 -> m_wren_o high one cycle with m_wdata_o=0x41, ack_o=01 two cycles after the request, err_o=0.
- Read: req1 read 0x10010000, model returns valid with 0x5A one cycle after m_rden_o -> ack_o=10, rdata_o=0x5A, err_o=0; only one m_rden_o pulse despite req held 3 cycles.
- Contention: req0 and req1 both held for 4 transactions -> grants alternate 0,1,0,1, and no two pulses occur in consecutive cycles.
- Unmapped read: read 0x20000000 -> no m_rden_o, ack with rdata_o=0 and err_o=1.
- Timeout (with UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): read 0x10010000 with the model never asserting valid -> ack with err_o=1 sixteen cycles after entering WAIT_RD; without the macro, no ack.
- Reset mid-read: rst_n_i low while in WAIT_RD -> all outputs 0 immediately, no ack afterward; a subsequent request is served normally.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART register-port arbiter:
//   - arb_state_e       : arbiter FSM encoding (IDLE=0, WAIT_RD=1, ACK=2)
//   - RBR_OFFSET        : receive-buffer register offset (0x0)
//   - THR_OFFSET        : transmit-holding register offset (0x4)
//   - BASE_ADDR_DEFAULT : default UART window base address
//   - in_uart_window()  : decode of a read that has a responder behind it
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_ACK     = 2'd2
  } arb_state_e;

  localparam logic [31:0] RBR_OFFSET        = 32'h0000_0000;
  localparam logic [31:0] THR_OFFSET        = 32'h0000_0004;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

  // A read only reaches the controller when the upper half matches the window
  // and the register field selects the one readable register (RBR).
  function automatic logic in_uart_window(input logic [15:0] addr_hi,
                                          input logic [3:0]  addr_reg,
                                          input logic [15:0] base_hi);
    return (addr_hi == base_hi) && (addr_reg == RBR_OFFSET[5:2]);
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at ptr_i and
// wraps modulo NUM_REQ; the first asserted request wins. Pointer storage is
// owned by the parent.
// Ports:
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle (must be < NUM_REQ)
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : encoded winner index
//   valid_o : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  logic [IW:0]   cand_s;
  logic          found_s;
  logic [IW-1:0] win_s;

  // Rotating priority search starting at the pointer.
  always_comb begin
    cand_s  = '0;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid_o = found_s;
  assign idx_o   = win_s;
  assign grant_o = found_s ? (NUM_REQ'(1) << win_s) : '0;

endmodule

// File: rtl/uart_bus_arbiter.sv
// -----------------------------------------------------------------------------
// uart_bus_arbiter
// Shares the UART controller's single 32-bit register port between NUM_REQ
// level-held requesters. One transaction at a time, round-robin fairness,
// exactly-one-cycle wren/rden pulses toward the controller, one-cycle ack back.
//
// Optional build macro UART_ARB_TIMEOUT_EN: WAIT_RD gives up after
// TIMEOUT_CYC cycles and completes with rdata=0, err=1. Without it a read
// waits for m_valid_i indefinitely.
//
// Ports:
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   req_i / req_we_i          : per-requester request (held to ack) / 1=write
//   req_addr_i / req_wdata_i  : flattened 32-bit fields, requester i at [32i+:32]
//   ack_o                     : one-hot, one-cycle completion
//   rdata_o / err_o           : completion data / error, held until next ack
//   m_addr_o / m_wdata_o      : latched address / write data to the controller
//   m_wren_o / m_rden_o       : single-cycle write / read pulses
//   m_rdata_i / m_valid_i     : controller read data / read-valid
// -----------------------------------------------------------------------------
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [32*NUM_REQ-1:0] req_addr_i,
  input  logic [32*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [31:0]           m_addr_o,
  output logic                  m_wren_o,
  output logic                  m_rden_o,
  output logic [31:0]           m_wdata_o,
  input  logic [31:0]           m_rdata_i,
  input  logic                  m_valid_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_r, state_s;
  logic [IW-1:0]       ptr_r, ptr_s;
  logic [IW-1:0]       idx_r, idx_s;
  logic                pend_err_r, pend_err_s;
  logic [31:0]         m_addr_r, m_addr_s;
  logic [31:0]         m_wdata_r, m_wdata_s;
  logic                m_wren_r, m_wren_s;
  logic                m_rden_r, m_rden_s;
  logic [NUM_REQ-1:0]  ack_r, ack_s;
  logic [31:0]         rdata_r, rdata_s;
  logic                err_r, err_s;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0]       tmo_r, tmo_s;
`endif

  logic [31:0]         addr_arr_s  [NUM_REQ];
  logic [31:0]         wdata_arr_s [NUM_REQ];
  logic [NUM_REQ-1:0]  gnt_onehot_s;
  logic [IW-1:0]       gnt_idx_s;
  logic                gnt_valid_s;
  logic [NUM_REQ-1:0]  ack_onehot_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_s[g]  = req_addr_i[32*g +: 32];
    assign wdata_arr_s[g] = req_wdata_i[32*g +: 32];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_r),
    .grant_o (gnt_onehot_s),
    .idx_o   (gnt_idx_s),
    .valid_o (gnt_valid_s)
  );

  assign ack_onehot_s = NUM_REQ'(1) << idx_r;

  // Next-state and next-output logic. ACK spans two cycles: the first issues
  // the ack register, the second (ack visible) returns to IDLE, so a request
  // still high while its ack is on the wire is never mistaken for a new one.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    idx_s      = idx_r;
    pend_err_s = pend_err_r;
    m_addr_s   = m_addr_r;
    m_wdata_s  = m_wdata_r;
    m_wren_s   = 1'b0;
    m_rden_s   = 1'b0;
    ack_s      = '0;
    rdata_s    = rdata_r;
    err_s      = err_r;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_s      = tmo_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          idx_s     = gnt_idx_s;
          m_addr_s  = addr_arr_s[gnt_idx_s];
          m_wdata_s = wdata_arr_s[gnt_idx_s];
          if (gnt_idx_s == IW'(NUM_REQ-1)) begin
            ptr_s = '0;
          end else begin
            ptr_s = gnt_idx_s + IW'(1);
          end
          if (req_we_i[gnt_idx_s]) begin
            m_wren_s   = 1'b1;
            pend_err_s = 1'b0;
            state_s    = ST_ACK;
          end else if (in_uart_window(addr_arr_s[gnt_idx_s][31:16],
                                      addr_arr_s[gnt_idx_s][5:2],
                                      BASE_ADDR[31:16])) begin
            m_rden_s = 1'b1;
            state_s  = ST_WAIT_RD;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_s    = '0;
`endif
          end else begin
            // No responder behind this address: complete with an error.
            pend_err_s = 1'b1;
            state_s    = ST_ACK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (m_valid_i) begin
          rdata_s = m_rdata_i;
          err_s   = 1'b0;
          ack_s   = ack_onehot_s;
          state_s = ST_ACK;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          if (tmo_r == TW'(TIMEOUT_CYC-1)) begin
            rdata_s = 32'h0000_0000;
            err_s   = 1'b1;
            ack_s   = ack_onehot_s;
            state_s = ST_ACK;
          end else begin
            tmo_s   = tmo_r + TW'(1);
            state_s = ST_WAIT_RD;
          end
`else
          state_s = ST_WAIT_RD;
`endif
        end
      end
      ST_ACK: begin
        if (|ack_r) begin
          state_s = ST_IDLE;
        end else begin
          ack_s   = ack_onehot_s;
          rdata_s = 32'h0000_0000;
          err_s   = pend_err_r;
          state_s = ST_ACK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched transaction fields and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      idx_r      <= '0;
      pend_err_r <= 1'b0;
      m_addr_r   <= 32'h0000_0000;
      m_wdata_r  <= 32'h0000_0000;
      m_wren_r   <= 1'b0;
      m_rden_r   <= 1'b0;
      ack_r      <= '0;
      rdata_r    <= 32'h0000_0000;
      err_r      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_r      <= '0;
`endif
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      idx_r      <= idx_s;
      pend_err_r <= pend_err_s;
      m_addr_r   <= m_addr_s;
      m_wdata_r  <= m_wdata_s;
      m_wren_r   <= m_wren_s;
      m_rden_r   <= m_rden_s;
      ack_r      <= ack_s;
      rdata_r    <= rdata_s;
      err_r      <= err_s;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_r      <= tmo_s;
`endif
    end
  end

  assign ack_o     = ack_r;
  assign rdata_o   = rdata_r;
  assign err_o     = err_r;
  assign m_addr_o  = m_addr_r;
  assign m_wdata_o = m_wdata_r;
  assign m_wren_o  = m_wren_r;
  assign m_rden_o  = m_rden_r;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_arbiter
// Directed bench for uart_bus_arbiter (NUM_REQ=2). A small controller model
// answers m_rden_o with m_valid_i one cycle later when enabled. Outputs are
// sampled 1 time unit after the rising edge; "cycle n" is the n-th edge after
// the request was driven.
// -----------------------------------------------------------------------------
module tb_uart_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  req_i, req_we_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic [1:0]  ack_o;
  logic [31:0] rdata_o, m_addr_o, m_wdata_o, m_rdata_i;
  logic        err_o, m_wren_o, m_rden_o, m_valid_i;

  logic        model_en;
  logic [31:0] model_data;

  int n_checks = 0;
  int n_errors = 0;
  int both_err = 0;
  int consec_err = 0;
  int rden_cnt = 0;
  int ack_cnt = 0;
  logic prev_pulse = 1'b0;

  always #5 clk_i = ~clk_i;

  uart_bus_arbiter #(.NUM_REQ(2), .BASE_ADDR(32'h1001_0000), .TIMEOUT_CYC(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .m_addr_o    (m_addr_o),
    .m_wren_o    (m_wren_o),
    .m_rden_o    (m_rden_o),
    .m_wdata_o   (m_wdata_o),
    .m_rdata_i   (m_rdata_i),
    .m_valid_i   (m_valid_i)
  );

  // UART controller model: read-valid one cycle after the read pulse.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_i <= 1'b0;
      m_rdata_i <= 32'h0;
    end else begin
      m_valid_i <= model_en && m_rden_o;
      m_rdata_i <= (model_en && m_rden_o) ? model_data : 32'h0;
    end
  end

  // Pulse monitor: no overlap, no back-to-back pulses; counts reads and acks.
  always @(negedge clk_i) begin
    if (m_wren_o && m_rden_o) both_err <= both_err + 1;
    if ((m_wren_o || m_rden_o) && prev_pulse) consec_err <= consec_err + 1;
    prev_pulse <= m_wren_o || m_rden_o;
    if (m_rden_o) rden_cnt <= rden_cnt + 1;
    if (|ack_o) ack_cnt <= ack_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) tick();
    n_checks++; if (ack_o !== 2'b00) begin n_errors++; $display("FAIL rst_ack: got %b want 00", ack_o); end
    n_checks++; if (rdata_o !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    n_checks++; if (m_addr_o !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h want 0", m_addr_o); end
    n_checks++; if ({m_wren_o, m_rden_o} !== 2'b00) begin n_errors++; $display("FAIL rst_pulses: got %b want 00", {m_wren_o, m_rden_o}); end
    n_checks++; if (m_wdata_o !== 32'h0) begin n_errors++; $display("FAIL rst_wdata: got %h want 0", m_wdata_o); end
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_write();
    req_we_i[0] = 1'b1;
    req_addr_i[31:0] = 32'h1001_0004;
    req_wdata_i[31:0] = 32'h0000_0041;
    req_i[0] = 1'b1;
    tick(); // cycle 1
    n_checks++; if (m_wren_o !== 1'b1) begin n_errors++; $display("FAIL wr_pulse: got %b want 1", m_wren_o); end
    n_checks++; if (m_wdata_o !== 32'h41) begin n_errors++; $display("FAIL wr_wdata: got %h want 41", m_wdata_o); end
    n_checks++; if (m_addr_o !== 32'h1001_0004) begin n_errors++; $display("FAIL wr_addr: got %h want 10010004", m_addr_o); end
    n_checks++; if (ack_o !== 2'b00) begin n_errors++; $display("FAIL wr_early_ack: got %b want 00", ack_o); end
    req_wdata_i[31:0] = 32'h0000_00FF; // must be ignored: fields are latched
    tick(); // cycle 2
    n_checks++; if (m_wren_o !== 1'b0) begin n_errors++; $display("FAIL wr_pulse_len: got %b want 0", m_wren_o); end
    n_checks++; if (ack_o !== 2'b01) begin n_errors++; $display("FAIL wr_ack: got %b want 01", ack_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL wr_err: got %b want 0", err_o); end
    n_checks++; if (m_wdata_o !== 32'h41) begin n_errors++; $display("FAIL wr_latched: got %h want 41", m_wdata_o); end
    req_i[0] = 1'b0;
    tick(); // cycle 3
    n_checks++; if (ack_o !== 2'b00) begin n_errors++; $display("FAIL wr_ack_len: got %b want 00", ack_o); end
    tick();
  endtask

  task automatic test_read();
    int r0;
    req_we_i[1] = 1'b0;
    req_addr_i[63:32] = 32'h1001_0000;
    model_en = 1'b1;
    model_data = 32'h0000_005A;
    r0 = rden_cnt;
    req_i[1] = 1'b1;
    tick(); // cycle 1
    n_checks++; if (m_rden_o !== 1'b1) begin n_errors++; $display("FAIL rd_pulse: got %b want 1", m_rden_o); end
    n_checks++; if (m_wren_o !== 1'b0) begin n_errors++; $display("FAIL rd_no_wren: got %b want 0", m_wren_o); end
    n_checks++; if (m_addr_o !== 32'h1001_0000) begin n_errors++; $display("FAIL rd_addr: got %h want 10010000", m_addr_o); end
    tick(); // cycle 2
    n_checks++; if (ack_o !== 2'b00) begin n_errors++; $display("FAIL rd_early_ack: got %b want 00", ack_o); end
    tick(); // cycle 3
    n_checks++; if (ack_o !== 2'b10) begin n_errors++; $display("FAIL rd_ack: got %b want 10", ack_o); end
    n_checks++; if (rdata_o !== 32'h5A) begin n_errors++; $display("FAIL rd_data: got %h want 5a", rdata_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL rd_err: got %b want 0", err_o); end
    n_checks++; if (rden_cnt - r0 !== 1) begin n_errors++; $display("FAIL rd_single_pulse: got %0d want 1", rden_cnt - r0); end
    req_i[1] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_contention();
    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    int cyc [4];
    int got;
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    got = 0;
    req_we_i = 2'b11;
    req_addr_i = {32'h1001_0004, 32'h1001_0004};
    req_wdata_i = {32'h0000_0022, 32'h0000_0011};
    req_i = 2'b11;
    for (int c = 1; c <= 20 && got < 4; c++) begin
      tick();
      if (|ack_o) begin
        seq[got] = ack_o;
        cyc[got] = c;
        got++;
        if (got == 4) req_i = 2'b00;
      end
    end
    n_checks++; if (got !== 4) begin n_errors++; $display("FAIL cont_count: got %0d acks want 4", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (seq[i] !== exp_seq[i]) begin n_errors++; $display("FAIL cont_order[%0d]: got %b want %b", i, seq[i], exp_seq[i]); end
      n_checks++; if (cyc[i] !== 2 + 3*i) begin n_errors++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, cyc[i], 2 + 3*i); end
    end
    n_checks++; if (m_wdata_o !== 32'h22) begin n_errors++; $display("FAIL cont_wdata: got %h want 22", m_wdata_o); end
    repeat (2) tick();
  endtask

  task automatic test_unmapped();
    int r0;
    req_we_i[0] = 1'b0;
    req_addr_i[31:0] = 32'h2000_0000;
    r0 = rden_cnt;
    req_i[0] = 1'b1;
    tick(); // cycle 1
    n_checks++; if ({m_wren_o, m_rden_o} !== 2'b00) begin n_errors++; $display("FAIL um_pulses: got %b want 00", {m_wren_o, m_rden_o}); end
    n_checks++; if (m_addr_o !== 32'h2000_0000) begin n_errors++; $display("FAIL um_addr: got %h want 20000000", m_addr_o); end
    tick(); // cycle 2
    n_checks++; if (ack_o !== 2'b01) begin n_errors++; $display("FAIL um_ack: got %b want 01", ack_o); end
    n_checks++; if (rdata_o !== 32'h0) begin n_errors++; $display("FAIL um_rdata: got %h want 0", rdata_o); end
    n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL um_err: got %b want 1", err_o); end
    req_i[0] = 1'b0;
    tick();
    n_checks++; if (rden_cnt !== r0) begin n_errors++; $display("FAIL um_no_rden: got %0d want %0d", rden_cnt, r0); end
    tick();
  endtask

  task automatic test_timeout();
    int at;
    logic got_err;
    logic [1:0] got_ack;
    at = 0;
    got_err = 1'b0;
    got_ack = 2'b00;
    model_en = 1'b0;
    req_we_i[0] = 1'b0;
    req_addr_i[31:0] = 32'h1001_0000;
    req_i[0] = 1'b1;
    for (int c = 1; c <= 40 && at == 0; c++) begin
      tick();
      if (|ack_o) begin
        at = c;
        got_err = err_o;
        got_ack = ack_o;
      end
    end
    req_i[0] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    // WAIT_RD entered in cycle 1; ack sixteen cycles later.
    n_checks++; if (at !== 17) begin n_errors++; $display("FAIL tmo_cycle: got %0d want 17", at); end
    n_checks++; if (got_err !== 1'b1) begin n_errors++; $display("FAIL tmo_err: got %b want 1", got_err); end
    n_checks++; if (got_ack !== 2'b01) begin n_errors++; $display("FAIL tmo_ack: got %b want 01", got_ack); end
`else
    n_checks++; if (at !== 0) begin n_errors++; $display("FAIL tmo_no_ack: ack in cycle %0d, want none", at); end
`endif
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_read();
    int a0;
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    model_en = 1'b0;
    req_we_i[1] = 1'b0;
    req_addr_i[63:32] = 32'h1001_0000;
    req_i = 2'b10;
    tick(); // cycle 1: read pulse
    n_checks++; if (m_rden_o !== 1'b1) begin n_errors++; $display("FAIL rm_pulse: got %b want 1", m_rden_o); end
    tick(); // cycle 2: in WAIT_RD
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++; if (m_addr_o !== 32'h0) begin n_errors++; $display("FAIL rm_addr: got %h want 0", m_addr_o); end
    n_checks++; if ({ack_o, err_o, m_wren_o, m_rden_o} !== 5'b0) begin n_errors++; $display("FAIL rm_ctrl: got %b want 00000", {ack_o, err_o, m_wren_o, m_rden_o}); end
    n_checks++; if ({rdata_o, m_wdata_o} !== 64'h0) begin n_errors++; $display("FAIL rm_data: got %h want 0", {rdata_o, m_wdata_o}); end
    req_i = 2'b00;
    a0 = ack_cnt;
    tick();
    rst_n_i = 1'b1;
    repeat (5) tick();
    n_checks++; if (ack_cnt !== a0) begin n_errors++; $display("FAIL rm_no_ack: got %0d acks want 0", ack_cnt - a0); end
    model_en = 1'b1;
    model_data = 32'h0000_00C3;
    req_i = 2'b10;
    tick(); // cycle 1
    n_checks++; if (m_rden_o !== 1'b1) begin n_errors++; $display("FAIL rm_retry_pulse: got %b want 1", m_rden_o); end
    repeat (2) tick(); // cycle 3
    n_checks++; if (ack_o !== 2'b10) begin n_errors++; $display("FAIL rm_retry_ack: got %b want 10", ack_o); end
    n_checks++; if (rdata_o !== 32'hC3) begin n_errors++; $display("FAIL rm_retry_data: got %h want c3", rdata_o); end
    req_i = 2'b00;
    repeat (2) tick();
  endtask

  initial begin
    rst_n_i = 1'b0;
    req_i = 2'b00;
    req_we_i = 2'b00;
    req_addr_i = 64'h0;
    req_wdata_i = 64'h0;
    model_en = 1'b0;
    model_data = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_unmapped();
    test_timeout();
    test_reset_mid_read();
    n_checks++; if (both_err !== 0) begin n_errors++; $display("FAIL pulse_overlap: got %0d want 0", both_err); end
    n_checks++; if (consec_err !== 0) begin n_errors++; $display("FAIL pulse_back_to_back: got %0d want 0", consec_err); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
